// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes,
// mux/ALU select values and the per-cycle control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       instrdone;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure Moore decode: maps the current state to its datapath control word.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.memread  = 1'b1;
                cw.irwrite  = 1'b1;
                cw.alusrcb  = SRCB_FOUR;
                cw.pcsource = PCSRC_ALU;
                cw.pcwrite  = 1'b1;
            end
            S_DECODE: begin
                cw.alusrcb = SRCB_IMMSH;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                cw.memread = 1'b1;
                cw.iord    = 1'b1;
            end
            S_MEMWB: begin
                cw.memtoreg  = 1'b1;
                cw.regwrite  = 1'b1;
                cw.instrdone = 1'b1;
            end
            S_MEMWR: begin
                cw.memwrite  = 1'b1;
                cw.iord      = 1'b1;
                cw.instrdone = 1'b1;
            end
            S_EXEC: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_B;
                cw.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.regdst    = 1'b1;
                cw.regwrite  = 1'b1;
                cw.instrdone = 1'b1;
            end
            // Branch polarity (beq vs bne) is resolved in the top against Zero.
            S_BEQ, S_BNE: begin
                cw.alusrca     = 1'b1;
                cw.aluop       = ALUOP_SUB;
                cw.pcwritecond = 1'b1;
                cw.pcsource    = PCSRC_ALUOUT;
                cw.instrdone   = 1'b1;
            end
            S_ADDIWB: begin
                cw.regwrite  = 1'b1;
                cw.instrdone = 1'b1;
            end
            S_JUMP: begin
                cw.pcwrite   = 1'b1;
                cw.pcsource  = PCSRC_JUMP;
                cw.instrdone = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: state register, opcode-driven sequencing,
// reset gating of every output and the PC load enable.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    logic   run;
    ctrl_t  cw;
    logic   illegal;
    logic   branch_ok;

    // run is cleared asynchronously with the state so outputs drop the instant
    // Rst rises, and it holds FETCH for one edge after release so the first
    // fetch word appears only in the cycle following that edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            run     <= 1'b0;
            state_q <= S_FETCH;
        end else begin
            run     <= 1'b1;
            state_q <= run ? state_d : S_FETCH;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state (state_q),
        .cw    (cw)
    );

    assign illegal   = (state_q == S_DECODE) && !op_supported(Opcode);
    assign branch_ok = (state_q == S_BNE) ? ~Zero : Zero;

    assign PCEn      = run & (cw.pcwrite | (cw.pcwritecond & branch_ok));
    assign IorD      = run & cw.iord;
    assign MemRead   = run & cw.memread;
    assign MemWrite  = run & cw.memwrite;
    assign IRWrite   = run & cw.irwrite;
    assign RegDst    = run & cw.regdst;
    assign MemtoReg  = run & cw.memtoreg;
    assign RegWrite  = run & cw.regwrite;
    assign ALUSrcA   = run & cw.alusrca;
    assign ALUSrcB   = run ? cw.alusrcb : 2'b00;
    assign ALUOp     = run ? cw.aluop : 2'b00;
    assign PCSource  = run ? cw.pcsource : 2'b00;
    assign InstrDone = run & (cw.instrdone | illegal);
    assign IllegalOp = run & illegal;
    assign State     = run ? state_q : 4'd0;

endmodule
